regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised successor to the 8x16 two-read/one-write register file. Depth and width are configurable, with an optional same-cycle write-through bypass. It adds a second write port for delayed (load-return) data and a per-register pending scoreboard, so the datapath controller can stall reads of registers awaiting late data. It sits between the microsequencer's ASEL/BSEL/DSEL fields and the ALU operand buses.

## Interface
- WIDTH, 16, data width in bits
- NREG, 8, number of architectural registers including R0; power of two, ≥2
- SELW, $clog2(NREG), select width (derived; do not override)
- BYPASS, 1, 1 = a same-cycle write is forwarded to the read buses; 0 = reads return stored value only

Ports. One clock; reset is asynchronous and active-high (CLK, RST).
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  asynchronous, active-high reset
- ASEL  in  SELW  A read select
- BSEL  in  SELW  B read select
- DSEL  in  SELW  primary write select; 0 = no write
- RIN  in  WIDTH  primary write data
- DIN  in  WIDTH  external input, returned on any read of select 0
- RSV  in  1  reserve strobe: mark register RSEL pending
- RSEL  in  SELW  register to reserve
- LWE  in  1  load-return write strobe
- LDSEL  in  SELW  load-return target
- LDIN  in  WIDTH  load-return data
- ABUS  out  WIDTH  A read data (combinational)
- BBUS  out  WIDTH  B read data (combinational)
- AVALID  out  1  ABUS holds non-pending data (combinational)
- BVALID  out  1  BBUS holds non-pending data (combinational)
- PENDCNT  out  SELW+1  number of pending registers (registered)
- ERR  out  3  registered one-cycle error pulses: [0] bad reserve, [1] unreserved return, [2] blocked write

## Operation
- Storage: registers 1..NREG-1, WIDTH bits each. R0 has no storage; selects of 0 read DIN. Writes, reserves and returns to R0 are ignored.
- Read path, per port X ∈ {A,B}, with sel = XSEL:
  - sel=0: XBUS=DIN, XVALID=1.
  - BYPASS=1 and LWE and LDSEL=sel: XBUS=LDIN, XVALID=1.
  - BYPASS=1 and an accepted primary write to sel: XBUS=RIN, XVALID=!pending[sel].
  - Otherwise: XBUS=reg[sel], XVALID=!pending[sel].
- Primary write (DSEL≠0) is accepted only if pending[DSEL]=0 and !(LWE && LDSEL=DSEL). Otherwise it is dropped and ERR[2] is pulsed.
- Load return (LWE, LDSEL≠0):
  - Always writes LDIN and clears pending[LDSEL].
  - If pending[LDSEL] was 0, the data is still written and ERR[1] is pulsed.
- Reserve (RSV, RSEL≠0):
  - Sets pending[RSEL].
  - If RSEL=0, or pending[RSEL] is already 1 and is not being cleared this cycle by LWE, the reserve is ignored and ERR[0] is pulsed.
- Same-cycle rules:
  - Reserve and return to the same register: data written, register ends pending (reserve wins the flag).
  - Return and primary write to the same register: return wins, ERR[2] pulsed.
  - Reads never block writes.
- PENDCNT tracks the population of the pending vector after each edge; it never exceeds NREG-1.

## Timing
- Writes, pending updates, PENDCNT and ERR take effect at the rising CLK edge following the strobe.
- Read latency is 0 cycles (combinational). A non-bypassed write is visible one edge later.
- ERR bits are high for exactly one cycle per offending edge; simultaneous errors set multiple bits.
- Reset values while RST=1, asynchronous: all registers 0, pending all 0, PENDCNT 0, ERR 0. ABUS/BBUS read 0 on selects ≠0 and DIN on select 0. AVALID=BVALID=1.
- RST asserted mid-reservation clears all pending state. A later LWE to that register raises ERR[1].

## Test plan
- Reset, then sweep ASEL/BSEL 1..7 with DIN=0 -> ABUS=BBUS=0, AVALID=BVALID=1, PENDCNT=0, ERR=0.
- Write RIN=k to DSEL=k for k=1..7, then read A and B with DIN=15 -> sel 0 gives 15, sel k gives k. Same-cycle write/read of R3 with BYPASS=1 -> RIN on the bus in the write cycle.
- RSV RSEL=5; read ASEL=5 -> AVALID=0, PENDCNT=1. Then LWE LDSEL=5 LDIN=0x1234 -> same cycle ABUS=0x1234, AVALID=1; next cycle PENDCNT=0.
- With R5 pending, DSEL=5 RIN=9 -> ERR=3'b100 for one cycle, R5 unchanged. LWE to non-pending R2 -> ERR=3'b010, R2 updated. RSV RSEL=0 -> ERR=3'b001.
- Same edge: RSV RSEL=4 plus LWE LDSEL=4 LDIN=7 -> R4=7, R4 still pending. Same edge: LWE LDSEL=6 plus DSEL=6 -> R6=LDIN, ERR[2]=1.
- Reserve R1..R7 -> PENDCNT=7. Assert RST mid-sequence -> PENDCNT=0, all reads return 0, valids high.

Source files
------------

// File: rtl/regfile_sb.sv
// Parametrised register file with a load-return write port and a per-register
// pending scoreboard, so reads of registers still waiting on late data can be stalled.
module regfile_sb #(
  parameter int WIDTH  = 16,
  parameter int NREG   = 8,
  parameter int SELW   = $clog2(NREG),
  parameter bit BYPASS = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [SELW-1:0]  ASEL,
  input  logic [SELW-1:0]  BSEL,
  input  logic [SELW-1:0]  DSEL,
  input  logic [WIDTH-1:0] RIN,
  input  logic [WIDTH-1:0] DIN,
  input  logic             RSV,
  input  logic [SELW-1:0]  RSEL,
  input  logic             LWE,
  input  logic [SELW-1:0]  LDSEL,
  input  logic [WIDTH-1:0] LDIN,
  output logic [WIDTH-1:0] ABUS,
  output logic [WIDTH-1:0] BBUS,
  output logic             AVALID,
  output logic             BVALID,
  output logic [SELW:0]    PENDCNT,
  output logic [2:0]       ERR
);

  logic [WIDTH-1:0] regs [NREG];
  logic [NREG-1:0]  pending;
  logic [NREG-1:0]  pending_next;
  logic [SELW:0]    count_next;

  logic ld_act;
  logic ld_hits_d;
  logic wr_req;
  logic wr_ok;
  logic rsv_bad;
  logic rsv_ok;
  logic [2:0] err_next;

  // A load return to a register always lands; a primary write to the same
  // register in that cycle loses and is reported as blocked.
  always_comb begin
    ld_act    = LWE && (LDSEL != '0);
    ld_hits_d = LWE && (LDSEL == DSEL);
    wr_req    = (DSEL != '0);
    wr_ok     = wr_req && !pending[DSEL] && !ld_hits_d;
    rsv_bad   = (RSEL == '0) || (pending[RSEL] && !(ld_act && (LDSEL == RSEL)));
    rsv_ok    = RSV && !rsv_bad;
    err_next  = {wr_req && !wr_ok, ld_act && !pending[LDSEL], RSV && rsv_bad};
  end

  // Reserve is applied after the return clear so it wins the pending flag.
  always_comb begin
    pending_next = pending;
    if (ld_act)
      pending_next[LDSEL] = 1'b0;
    if (rsv_ok)
      pending_next[RSEL] = 1'b1;
    pending_next[0] = 1'b0;
    count_next = '0;
    for (int i = 1; i < NREG; i++)
      count_next = count_next + (SELW+1)'(pending_next[i]);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
      pending <= '0;
      PENDCNT <= '0;
      ERR     <= '0;
    end else begin
      if (wr_ok)
        regs[DSEL] <= RIN;
      if (ld_act)
        regs[LDSEL] <= LDIN;
      pending <= pending_next;
      PENDCNT <= count_next;
      ERR     <= err_next;
    end
  end

  // Returns {valid, data} for one read port.
  function automatic logic [WIDTH:0] read_port(input logic [SELW-1:0] sel);
    logic [WIDTH:0] r;
    if (sel == '0)
      r = {1'b1, DIN};
    else if (BYPASS && LWE && (LDSEL == sel))
      r = {1'b1, LDIN};
    else if (BYPASS && wr_ok && (DSEL == sel))
      r = {!pending[sel], RIN};
    else
      r = {!pending[sel], regs[sel]};
    return r;
  endfunction

  always_comb begin
    {AVALID, ABUS} = read_port(ASEL);
    {BVALID, BBUS} = read_port(BSEL);
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard testbench for regfile_sb: a behavioural model pushes expected bus,
// valid, count and error values, which are popped and compared against the DUT.
module tb_regfile_sb;
  localparam int WIDTH = 16;
  localparam int NREG  = 8;
  localparam int SELW  = 3;

  logic             CLK = 1'b0;
  logic             RST;
  logic [SELW-1:0]  ASEL, BSEL, DSEL, RSEL, LDSEL;
  logic [WIDTH-1:0] RIN, DIN, LDIN;
  logic             RSV, LWE;
  logic [WIDTH-1:0] ABUS, BBUS;
  logic             AVALID, BVALID;
  logic [SELW:0]    PENDCNT;
  logic [2:0]       ERR;

  regfile_sb #(.WIDTH(WIDTH), .NREG(NREG), .BYPASS(1'b1)) dut (
    .CLK(CLK), .RST(RST), .ASEL(ASEL), .BSEL(BSEL), .DSEL(DSEL), .RIN(RIN),
    .DIN(DIN), .RSV(RSV), .RSEL(RSEL), .LWE(LWE), .LDSEL(LDSEL), .LDIN(LDIN),
    .ABUS(ABUS), .BBUS(BBUS), .AVALID(AVALID), .BVALID(BVALID),
    .PENDCNT(PENDCNT), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  string       tagQ[$];
  logic [31:0] expQ[$];

  logic [WIDTH-1:0] mreg [NREG];
  logic [NREG-1:0]  mpend;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pushExp(input string tag, input logic [31:0] exp);
    tagQ.push_back(tag);
    expQ.push_back(exp);
  endtask

  task automatic popCheck(input logic [31:0] obs);
    if (expQ.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      checkOutput(tagQ.pop_front(), obs, expQ.pop_front());
    end
  endtask

  function automatic logic [WIDTH:0] modelRead(input logic [SELW-1:0] sel);
    logic wok;
    wok = (DSEL != 0) && !mpend[DSEL] && !(LWE && LDSEL == DSEL);
    if (sel == 0)                  return {1'b1, DIN};
    if (LWE && LDSEL == sel)       return {1'b1, LDIN};
    if (wok && DSEL == sel)        return {!mpend[sel], RIN};
    return {!mpend[sel], mreg[sel]};
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NREG; i++) mreg[i] = '0;
    mpend = '0;
  endtask

  task automatic idleInputs();
    ASEL = 0; BSEL = 0; DSEL = 0; RSEL = 0; LDSEL = 0;
    RIN = 0; DIN = 0; LDIN = 0; RSV = 0; LWE = 0;
  endtask

  // Drives one cycle of stimulus (called just after a rising edge), scores the
  // combinational read path before the next edge and the registered outputs after it.
  task automatic applyStimulus(input logic [SELW-1:0] a, input logic [SELW-1:0] b,
                               input logic [SELW-1:0] d, input logic [WIDTH-1:0] rin,
                               input logic [WIDTH-1:0] din, input logic rsv,
                               input logic [SELW-1:0] rsel, input logic lwe,
                               input logic [SELW-1:0] ldsel, input logic [WIDTH-1:0] ldin);
    logic [WIDTH:0]   ra, rb;
    logic [NREG-1:0]  np;
    logic [WIDTH-1:0] nreg [NREG];
    logic ld, wok, bad;
    logic [2:0] e;
    ASEL = a; BSEL = b; DSEL = d; RIN = rin; DIN = din;
    RSV = rsv; RSEL = rsel; LWE = lwe; LDSEL = ldsel; LDIN = ldin;
    #1;
    ra = modelRead(a);
    rb = modelRead(b);
    ld  = lwe && ldsel != 0;
    wok = (d != 0) && !mpend[d] && !(lwe && ldsel == d);
    bad = (rsel == 0) || (mpend[rsel] && !(ld && ldsel == rsel));
    e   = {(d != 0) && !wok, ld && !mpend[ldsel], rsv && bad};
    np = mpend;
    for (int i = 0; i < NREG; i++) nreg[i] = mreg[i];
    if (ld) np[ldsel] = 1'b0;
    if (rsv && !bad) np[rsel] = 1'b1;
    if (wok) nreg[d] = rin;
    if (ld) nreg[ldsel] = ldin;
    pushExp("ABUS", 32'(ra[WIDTH-1:0]));
    pushExp("AVALID", 32'(ra[WIDTH]));
    pushExp("BBUS", 32'(rb[WIDTH-1:0]));
    pushExp("BVALID", 32'(rb[WIDTH]));
    pushExp("PENDCNT", 32'($countones(np)));
    pushExp("ERR", 32'(e));
    popCheck(32'(ABUS));
    popCheck(32'(AVALID));
    popCheck(32'(BBUS));
    popCheck(32'(BVALID));
    @(posedge CLK);
    #1;
    mpend = np;
    for (int i = 0; i < NREG; i++) mreg[i] = nreg[i];
    popCheck(32'(PENDCNT));
    popCheck(32'(ERR));
  endtask

  task automatic idleCycle(input logic [SELW-1:0] a, input logic [SELW-1:0] b);
    applyStimulus(a, b, 0, 0, 16'hF, 0, 0, 0, 0, 0);
  endtask

  task automatic checkResetState();
    checkOutput("rst_PENDCNT", 32'(PENDCNT), 32'd0);
    checkOutput("rst_ERR", 32'(ERR), 32'd0);
    for (int s = 1; s < NREG; s++) begin
      ASEL = SELW'(s); BSEL = SELW'(NREG - s);
      #1;
      checkOutput("rst_ABUS", 32'(ABUS), 32'd0);
      checkOutput("rst_BBUS", 32'(BBUS), 32'd0);
      checkOutput("rst_AVALID", 32'(AVALID), 32'd1);
      checkOutput("rst_BVALID", 32'(BVALID), 32'd1);
    end
    ASEL = 0; DIN = 16'h00A5;
    #1;
    checkOutput("rst_ABUS_sel0", 32'(ABUS), 32'h00A5);
    DIN = 0;
  endtask

  initial begin
    idleInputs();
    modelReset();
    RST = 1'b1;
    #2;
    checkResetState();
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // Fill R1..R7, bypass visible in the write cycle itself.
    for (int k = 1; k < NREG; k++)
      applyStimulus(SELW'(k), SELW'(k), SELW'(k), WIDTH'(k), 16'd15, 0, 0, 0, 0, 0);
    for (int k = 0; k < NREG; k++)
      idleCycle(SELW'(k), SELW'((k + 3) % NREG));
    applyStimulus(3, 3, 3, 16'hAAAA, 16'd15, 0, 0, 0, 0, 0);
    idleCycle(3, 0);

    // Reserve R5, observe stall, then return.
    applyStimulus(5, 5, 0, 0, 0, 1, 5, 0, 0, 0);
    checkOutput("pend_after_rsv5", 32'(PENDCNT), 32'd1);
    idleCycle(5, 1);
    applyStimulus(5, 2, 0, 0, 0, 0, 0, 1, 5, 16'h1234);
    idleCycle(5, 5);

    // Blocked write, unreserved return, bad reserve.
    applyStimulus(0, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    applyStimulus(5, 0, 5, 16'd9, 0, 0, 0, 0, 0, 0);
    checkOutput("err_blocked_write", 32'(ERR), 32'b100);
    applyStimulus(5, 0, 0, 0, 0, 0, 0, 1, 5, 16'h5555);
    applyStimulus(2, 5, 0, 0, 0, 0, 0, 1, 2, 16'h2222);
    checkOutput("err_unreserved_ret", 32'(ERR), 32'b010);
    applyStimulus(2, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    checkOutput("err_bad_reserve", 32'(ERR), 32'b001);
    applyStimulus(0, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    checkOutput("err_double_reserve", 32'(ERR), 32'b001);
    applyStimulus(0, 0, 0, 0, 0, 1, 5, 1, 5, 16'h0505);

    // Same-edge rules.
    applyStimulus(4, 4, 0, 0, 0, 1, 4, 1, 4, 16'd7);
    applyStimulus(4, 6, 6, 16'hBEEF, 0, 0, 0, 1, 6, 16'h0666);
    checkOutput("err_ret_vs_write", 32'(ERR[2]), 32'd1);
    idleCycle(4, 6);
    applyStimulus(4, 0, 0, 0, 0, 0, 0, 1, 4, 16'h0044);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5, 16'h0055);

    // Reserve everything, then reset in the middle of a cycle.
    for (int k = 1; k < NREG; k++)
      applyStimulus(SELW'(k), 0, 0, 0, 0, 1, SELW'(k), 0, 0, 0);
    checkOutput("pend_all", 32'(PENDCNT), 32'd7);
    applyStimulus(3, 7, 0, 0, 0, 1, 3, 0, 0, 0);
    #2;
    idleInputs();
    RST = 1'b1;
    #1;
    modelReset();
    checkResetState();
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    applyStimulus(3, 3, 0, 0, 0, 0, 0, 1, 3, 16'h0333);
    checkOutput("err_ret_after_rst", 32'(ERR), 32'b010);

    // Random traffic against the model.
    for (int n = 0; n < 200; n++)
      applyStimulus(SELW'($urandom_range(0, 7)), SELW'($urandom_range(0, 7)),
                    SELW'($urandom_range(0, 7)), WIDTH'($urandom),
                    WIDTH'($urandom), 1'($urandom_range(0, 1)),
                    SELW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    SELW'($urandom_range(0, 7)), WIDTH'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
